mem_dump_engine: RTL and testbench

- Synthesizable, parametrised data-memory scan engine. It replaces the simulation-only loop that dumps data memory at end of test.
- On a start command it reads an inclusive address range from one synchronous-read port of the data memory.
- It streams each word with its address over a valid/ready channel and accumulates a rotate-XOR signature, so benches and FPGA debug logic can check memory contents.
- It sits beside DMEM and shares the read port through an external mux while the core is halted.

---
 rtl/mem_dump_engine_pkg.sv | 31 +++
 rtl/mem_dump_engine_sig.sv | 41 ++++
 rtl/mem_dump_engine.sv | 151 +++++++++++++++
 tb/tb_mem_dump_engine.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dump_engine_pkg.sv
// Shared definitions for the data-memory dump engine: default geometry,
// FSM state encoding and the signature rotate helper.
package mem_dump_engine_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 10;

  // Widest signature the rotate helper supports.
  localparam int unsigned SIG_MAX_WIDTH  = 64;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_CAPT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Rotate the low 'width' bits of v left by one.
  // Bits of v above 'width' must be zero.
  function automatic logic [SIG_MAX_WIDTH-1:0] sig_rotl1(
    input logic [SIG_MAX_WIDTH-1:0] v,
    input int unsigned              width
  );
    logic [SIG_MAX_WIDTH-1:0] mask;
    mask = (width >= SIG_MAX_WIDTH) ? '1
                                    : ((SIG_MAX_WIDTH'(1) << width) - SIG_MAX_WIDTH'(1));
    return ((v << 1) | (v >> (width - 1))) & mask;
  endfunction

endpackage

// File: rtl/mem_dump_engine_sig.sv
// Rotate-XOR signature accumulator. Clear has priority over enable.
// Each enabled cycle computes sig = rotl1(sig) ^ din.
module mem_dump_sig
  import mem_dump_engine_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] sig
);

  logic [DATA_WIDTH-1:0] sig_q, sig_d;

  // Next-signature selection: clear, accumulate or hold.
  always_comb begin
    // NOTE: default first so every path assigns sig_d; otherwise a latch is inferred.
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = DATA_WIDTH'(sig_rotl1(SIG_MAX_WIDTH'(sig_q), DATA_WIDTH)) ^ din;
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking in clocked blocks so all registers update from pre-edge values.
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/mem_dump_engine.sv
// Data-memory scan engine. It reads an inclusive address range through one
// synchronous-read DMEM port and can stream each word with its address over
// a valid/ready channel. It also accumulates a signature of every word read.
module mem_dump_engine
  import mem_dump_engine_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic                  stream_en,
  input  logic                  skip_zero,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  aborted,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [DATA_WIDTH-1:0] signature
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cur_q, end_q, addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  stream_q, skip_q, last_q;
  logic                  err_q, aborted_q;
  logic [ADDR_WIDTH:0]   wc_q;

  logic at_end, emit, sig_clr, sig_en;

  // The range ends on equality, so a top-of-memory end address cannot wrap.
  assign at_end  = (cur_q == end_q);
  assign emit    = stream_q && !(skip_q && (mem_rdata == '0));
  assign sig_clr = (state_q == ST_IDLE) && start;
  assign sig_en  = (state_q == ST_CAPT) && !abort;

  // Scan FSM with address counter, capture registers and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      end_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      stream_q  <= 1'b0;
      skip_q    <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
      wc_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cur_q     <= start_addr;
            end_q     <= end_addr;
            stream_q  <= stream_en;
            skip_q    <= skip_zero;
            wc_q      <= '0;
            aborted_q <= 1'b0;
            if (end_addr < start_addr) begin
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              err_q   <= 1'b0;
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (abort) begin
            aborted_q <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            state_q <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          if (abort) begin
            aborted_q <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            data_q <= mem_rdata;
            addr_q <= cur_q;
            last_q <= at_end;
            if (emit) begin
              state_q <= ST_SEND;
            end else if (at_end) begin
              state_q <= ST_DONE;
            end else begin
              cur_q   <= cur_q + ADDR_WIDTH'(1);
              state_q <= ST_READ;
            end
          end
        end
        ST_SEND: begin
          if (abort) begin
            aborted_q <= 1'b1;
            state_q   <= ST_DONE;
          end else if (out_ready) begin
            wc_q <= wc_q + (ADDR_WIDTH+1)'(1);
            if (at_end) begin
              state_q <= ST_DONE;
            end else begin
              cur_q   <= cur_q + ADDR_WIDTH'(1);
              state_q <= ST_READ;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  mem_dump_sig #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sig (
    .clk   (clk),
    .rst_n (rst),
    .clr   (sig_clr),
    .en    (sig_en),
    .din   (mem_rdata),
    .sig   (signature)
  );

  assign mem_re     = (state_q == ST_READ);
  assign mem_addr   = mem_re ? cur_q : '0;
  assign out_valid  = (state_q == ST_SEND);
  assign out_addr   = addr_q;
  assign out_data   = data_q;
  assign out_last   = out_valid && last_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign aborted    = aborted_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_mem_dump_engine.sv
// Directed bench for mem_dump_engine with a synchronous-read memory model.
module tb_mem_dump_engine;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, stream_en, skip_zero, out_ready;
  logic [AW-1:0] start_addr, end_addr;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          out_valid, out_last, busy, done, err, aborted;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [AW:0]   word_count;
  logic [DW-1:0] signature;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  logic [AW-1:0] hs_addr[$];
  logic [DW-1:0] hs_data[$];
  logic          hs_last[$];
  logic [AW-1:0] re_log[$];
  int            done_cnt;

  mem_dump_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .stream_en  (stream_en),
    .skip_zero  (skip_zero),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .aborted    (aborted),
    .word_count (word_count),
    .signature  (signature)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data valid one cycle after mem_re.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Channel / read / done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      hs_addr.push_back(out_addr);
      hs_data.push_back(out_data);
      hs_last.push_back(out_last);
    end
    if (mem_re) re_log.push_back(mem_addr);
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_logs();
    hs_addr.delete();
    hs_data.delete();
    hs_last.delete();
    re_log.delete();
    done_cnt = 0;
  endtask

  // Returns at the falling edge of the cycle right after the start edge.
  task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] e,
                          input logic st, input logic sk);
    @(negedge clk);
    start_addr = s;
    end_addr   = e;
    stream_en  = st;
    skip_zero  = sk;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Steps falling edges until done; k counts cycles after the start edge.
  task automatic wait_done(input string tag, input int k0, input int budget, output int k);
    k = k0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, done, 1);
  endtask

  int k;
  int guard;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; stream_en = 1'b0; skip_zero = 1'b0;
    out_ready = 1'b1; start_addr = '0; end_addr = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
    mem[8] = 32'h11; mem[9] = 32'h0; mem[10] = 32'h22;
    mem[1023] = 32'hDEAD_BEEF;
    clear_logs();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_sig", signature, 0);
    check("rst_wc", word_count, 0);
    check("rst_err", err, 0);
    check("rst_aborted", aborted, 0);
    rst = 1'b1;
    @(negedge clk);

    // Full range 0..3, streaming. sig: 0 -> 0 -> 1 -> (2^2)=0 -> (0^3)=3
    clear_logs();
    do_start(10'd0, 10'd3, 1'b1, 1'b0);
    check("t1_mem_re_n1", mem_re, 1);
    check("t1_mem_addr_n1", mem_addr, 0);
    @(negedge clk);
    check("t1_valid_n2", out_valid, 0);
    @(negedge clk);
    check("t1_valid_n3", out_valid, 1);
    wait_done("t1", 3, 40, k);
    check("t1_cycles", k, 13);
    repeat (2) @(negedge clk);
    check("t1_hs_n", hs_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_addr%0d", i), hs_addr[i], i);
      check($sformatf("t1_data%0d", i), hs_data[i], i);
      check($sformatf("t1_last%0d", i), hs_last[i], (i == 3));
    end
    check("t1_wc", word_count, 4);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_sig", signature, 32'h3);
    check("t1_busy", busy, 0);

    // Skip zero over 8..10: sig = rot(rot(0x11)) ^ 0x22 = 0x66
    clear_logs();
    do_start(10'd8, 10'd10, 1'b1, 1'b1);
    wait_done("t2", 1, 40, k);
    check("t2_cycles", k, 9);
    repeat (2) @(negedge clk);
    check("t2_hs_n", hs_addr.size(), 2);
    check("t2_addr0", hs_addr[0], 8);
    check("t2_data0", hs_data[0], 32'h11);
    check("t2_last0", hs_last[0], 0);
    check("t2_addr1", hs_addr[1], 10);
    check("t2_data1", hs_data[1], 32'h22);
    check("t2_last1", hs_last[1], 1);
    check("t2_wc", word_count, 2);
    check("t2_sig", signature, 32'h66);
    check("t2_reads", re_log.size(), 3);

    // Backpressure on range 4..5
    clear_logs();
    out_ready = 1'b0;
    do_start(10'd4, 10'd5, 1'b1, 1'b0);
    guard = 0;
    while (!out_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("t3_valid_seen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_hold_valid%0d", i), out_valid, 1);
      check($sformatf("t3_hold_data%0d", i), out_data, 4);
      check($sformatf("t3_hold_addr%0d", i), out_addr, 4);
      check($sformatf("t3_hold_re%0d", i), mem_re, 0);
      @(negedge clk);
    end
    check("t3_reads_held", re_log.size(), 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_re_after_hs", mem_re, 1);
    check("t3_re_addr_after_hs", mem_addr, 5);
    wait_done("t3", 0, 40, k);
    repeat (2) @(negedge clk);
    check("t3_hs_n", hs_addr.size(), 2);
    check("t3_data1", hs_data[1], 5);
    check("t3_wc", word_count, 2);

    // Single word at top of memory
    clear_logs();
    do_start(10'h3FF, 10'h3FF, 1'b1, 1'b0);
    wait_done("t4", 1, 40, k);
    check("t4_cycles", k, 4);
    repeat (3) @(negedge clk);
    check("t4_reads", re_log.size(), 1);
    check("t4_read_addr", re_log[0], 10'h3FF);
    check("t4_hs_n", hs_addr.size(), 1);
    check("t4_hs_addr", hs_addr[0], 10'h3FF);
    check("t4_hs_data", hs_data[0], 32'hDEAD_BEEF);
    check("t4_hs_last", hs_last[0], 1);
    check("t4_wc", word_count, 1);
    check("t4_sig", signature, 32'hDEAD_BEEF);
    check("t4_busy", busy, 0);
    check("t4_done_cnt", done_cnt, 1);

    // Reversed range: err, immediate done, no reads
    clear_logs();
    do_start(10'd5, 10'd4, 1'b1, 1'b0);
    check("t5_done_n1", done, 1);
    check("t5_err", err, 1);
    check("t5_mem_re", mem_re, 0);
    check("t5_wc", word_count, 0);
    check("t5_sig_cleared", signature, 0);
    repeat (2) @(negedge clk);
    check("t5_reads", re_log.size(), 0);
    check("t5_err_sticky", err, 1);
    check("t5_done_cnt", done_cnt, 1);

    // Abort during SEND of the second word of 0..7
    clear_logs();
    do_start(10'd0, 10'd7, 1'b1, 1'b0);
    check("t6_err_cleared", err, 0);
    guard = 0;
    while (!(out_valid && out_addr == 10'd1) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("t6_second_seen", out_valid && (out_addr == 10'd1), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t6_valid_drop", out_valid, 0);
    check("t6_done", done, 1);
    check("t6_aborted", aborted, 1);
    check("t6_wc", word_count, 1);
    repeat (2) @(negedge clk);
    check("t6_done_cnt", done_cnt, 1);
    check("t6_aborted_sticky", aborted, 1);
    do_start(10'd2, 10'd2, 1'b1, 1'b0);
    check("t6_aborted_cleared", aborted, 0);
    wait_done("t6b", 1, 40, k);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-scan
    clear_logs();
    do_start(10'd0, 10'd3, 1'b1, 1'b0);
    guard = 0;
    while (!(mem_re && mem_addr == 10'd2) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("t7_read2_seen", mem_re && (mem_addr == 10'd2), 1);
    check("t7_sig_before", signature, 1);
    #2 rst = 1'b0;
    #1;
    check("t7_mem_re", mem_re, 0);
    check("t7_busy", busy, 0);
    check("t7_sig", signature, 0);
    check("t7_valid", out_valid, 0);
    check("t7_wc", word_count, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t7_no_done%0d", i), done, 0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t7_idle_after", busy, 0);
    check("t7_done_cnt", done_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
